// File: rtl/fifo_rd_stream.sv
// Read-side master for async_fifo: drains the FIFO read port into a 2-entry
// output buffer and presents the words as a valid/ready stream.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rst,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rempty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic       capture;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] used;
  logic [2:0] room;

  always_comb begin
    occ = 2'd0;
    case (state_q)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  assign capture = inflight_q;
  assign m_valid = (state_q != EMPTY);
  assign pop     = m_valid & m_ready;
  assign m_data  = head_q;
  assign rd_cnt  = cnt_q;

  // A pop this cycle frees a slot by the time the word lands, so it counts as
  // credit; without it the ONE+inflight steady state would stall every 3rd cycle.
  assign used = {1'b0, occ} + {2'b00, inflight_q};
  assign room = 3'd2 + {2'b00, pop};
  assign ren  = !rst && !rempty && (used < room);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    if (pop) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      EMPTY: begin
        if (capture) begin
          head_d  = rdata;
          state_d = ONE;
        end
      end
      ONE: begin
        if (capture && !pop) begin
          ent1_d  = rdata;
          state_d = TWO;
        end else if (capture && pop) begin
          head_d  = rdata;
          state_d = ONE;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = ent1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      ent1_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= ren;
      head_q     <= head_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
